// File: rtl/h264_vlc_pkg.sv
// Shared types and constants for the H.264 VLC scheduler: scheduler states,
// code word widths, the RBSP stop-bit code and the buffered word format.
package h264_vlc_pkg;

    localparam int VEW = 25;
    localparam int VLW = 5;

    localparam logic [VEW-1:0] STOP_VE = VEW'(1);
    localparam logic [VLW-1:0] STOP_VL = VLW'(1);

    typedef enum logic [1:0] {
        HDR,
        RES,
        STOP,
        ALIGN
    } sched_state_t;

    typedef struct packed {
        logic           last;
        logic [VLW-1:0] vl;
        logic [VEW-1:0] ve;
    } vlc_word_t;

endpackage

// File: rtl/h264_sync_fifo.sv
// Synchronous flip-flop FIFO. Pointers carry one extra wrap bit so that full
// and empty are told apart by comparing the MSBs and the index bits.
module h264_sync_fifo #(
    parameter int WIDTH = 31,
    parameter int DEPTH = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o = (wr_q == rd_q);
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a full FIFO may still accept.
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_q[AW-1:0]];

    assign wr_d = wr_q + {{AW{1'b0}}, do_push};
    assign rd_d = rd_q + {{AW{1'b0}}, do_pop};

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values regardless of block order.
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // NOTE: storage is deliberately not reset; flushing the pointers makes any
    // stale contents unreachable and keeps the array free of reset fan-out.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/h264_vlc_sched.sv
// Per-macroblock scheduler: buffers header and residual VLC words and emits
// all header words, then all residual words, plus the slice stop bit/align.
module h264_vlc_sched
    import h264_vlc_pkg::*;
#(
    parameter int HDEPTH = 16,
    parameter int RDEPTH = 32
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic [19:0]    HVE,
    input  logic [4:0]     HVL,
    input  logic           HVALID,
    input  logic           HLAST,
    input  logic [VEW-1:0] RVE,
    input  logic [VLW-1:0] RVL,
    input  logic           RVALID,
    input  logic           RLAST,
    input  logic           SLICEEND,
    output logic [VEW-1:0] VE,
    output logic [VLW-1:0] VL,
    output logic           VALID,
    output logic           ALIGN,
    output logic           OVF,
    output logic           BUSY
);

    sched_state_t   state_q, state_d;
    logic           pend_q, pend_d;
    logic [VEW-1:0] ve_q, ve_d;
    logic [VLW-1:0] vl_q, vl_d;
    logic           valid_q, valid_d;
    logic           align_q, align_d;
    logic           ovf_q, ovf_d;

    vlc_word_t h_in, h_out, r_in, r_out;
    logic      h_push, h_pop, h_full, h_empty;
    logic      r_push, r_pop, r_full, r_empty;

    assign h_in.last = HLAST;
    assign h_in.vl   = HVL;
    assign h_in.ve   = VEW'(HVE);
    assign r_in.last = RLAST;
    assign r_in.vl   = RVL;
    assign r_in.ve   = RVE;

    // Zero-length words only survive when they carry the end-of-MB tag.
    assign h_push = HVALID && ((HVL != '0) || HLAST);
    assign r_push = RVALID && ((RVL != '0) || RLAST);

    h264_sync_fifo #(.WIDTH($bits(vlc_word_t)), .DEPTH(HDEPTH)) u_hdr_fifo (
        .CLK     (CLK),
        .RESET   (RESET),
        .push_i  (h_push),
        .data_i  (h_in),
        .pop_i   (h_pop),
        .data_o  (h_out),
        .full_o  (h_full),
        .empty_o (h_empty)
    );

    h264_sync_fifo #(.WIDTH($bits(vlc_word_t)), .DEPTH(RDEPTH)) u_res_fifo (
        .CLK     (CLK),
        .RESET   (RESET),
        .push_i  (r_push),
        .data_i  (r_in),
        .pop_i   (r_pop),
        .data_o  (r_out),
        .full_o  (r_full),
        .empty_o (r_empty)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned and infers a latch.
        state_d = state_q;
        pend_d  = pend_q;
        h_pop   = 1'b0;
        r_pop   = 1'b0;
        ve_d    = '0;
        vl_d    = '0;
        valid_d = 1'b0;
        align_d = 1'b0;
        case (state_q)
            HDR: begin
                // A pending slice end closes the slice before next-slice headers.
                if (pend_q) begin
                    state_d = STOP;
                end else if (!h_empty) begin
                    h_pop = 1'b1;
                    if (h_out.vl != '0) begin
                        ve_d    = h_out.ve;
                        vl_d    = h_out.vl;
                        valid_d = 1'b1;
                    end
                    if (h_out.last) state_d = RES;
                end
            end
            RES: begin
                if (!r_empty) begin
                    r_pop = 1'b1;
                    if (r_out.vl != '0) begin
                        ve_d    = r_out.ve;
                        vl_d    = r_out.vl;
                        valid_d = 1'b1;
                    end
                    if (r_out.last) state_d = HDR;
                end
            end
            STOP: begin
                ve_d    = STOP_VE;
                vl_d    = STOP_VL;
                valid_d = 1'b1;
                state_d = h264_vlc_pkg::ALIGN;  // bare ALIGN names the output port here
            end
            h264_vlc_pkg::ALIGN: begin
                align_d = 1'b1;
                pend_d  = 1'b0;
                state_d = HDR;
            end
            default: state_d = HDR;
        endcase
        // Applied last so a slice end coinciding with the align-cycle clear is kept.
        if (SLICEEND) pend_d = 1'b1;
        ovf_d = ovf_q || (h_push && h_full && !h_pop) || (r_push && r_full && !r_pop);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= HDR;
            pend_q  <= 1'b0;
            ve_q    <= '0;
            vl_q    <= '0;
            valid_q <= 1'b0;
            align_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ve_q    <= ve_d;
            vl_q    <= vl_d;
            valid_q <= valid_d;
            align_q <= align_d;
            ovf_q   <= ovf_d;
        end
    end

    assign VE    = ve_q;
    assign VL    = vl_q;
    assign VALID = valid_q;
    assign ALIGN = align_q;
    assign OVF   = ovf_q;
    assign BUSY  = (state_q != HDR) || pend_q || !h_empty || !r_empty;

endmodule

// File: tb/tb_h264_vlc_sched.sv
// Directed bench for h264_vlc_sched: hand-computed output sequences checked
// with immediate assertions one cycle at a time.
module tb_h264_vlc_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] hve = '0;
    logic [4:0]  hvl = '0;
    logic        hvalid = 1'b0;
    logic        hlast = 1'b0;
    logic [24:0] rve = '0;
    logic [4:0]  rvl = '0;
    logic        rvalid = 1'b0;
    logic        rlast = 1'b0;
    logic        sliceend = 1'b0;
    logic [24:0] ve;
    logic [4:0]  vl;
    logic        valid;
    logic        align;
    logic        ovf;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    h264_vlc_sched #(.HDEPTH(16), .RDEPTH(32)) dut (
        .CLK      (clk),
        .RESET    (rst),
        .HVE      (hve),
        .HVL      (hvl),
        .HVALID   (hvalid),
        .HLAST    (hlast),
        .RVE      (rve),
        .RVL      (rvl),
        .RVALID   (rvalid),
        .RLAST    (rlast),
        .SLICEEND (sliceend),
        .VE       (ve),
        .VL       (vl),
        .VALID    (valid),
        .ALIGN    (align),
        .OVF      (ovf),
        .BUSY     (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [24:0] e_ve, input logic [4:0] e_vl);
        chk(tag, {1'b0, valid, vl, ve}, {1'b0, 1'b1, e_vl, e_ve});
    endtask

    task automatic chk_idle(input string tag);
        chk(tag, 32'(valid), 32'd0);
    endtask

    task automatic hset(input logic [19:0] v, input logic [4:0] l, input logic last);
        hve = v; hvl = l; hlast = last; hvalid = 1'b1;
    endtask

    task automatic rset(input logic [24:0] v, input logic [4:0] l, input logic last);
        rve = v; rvl = l; rlast = last; rvalid = 1'b1;
    endtask

    task automatic clr();
        hvalid = 1'b0; hlast = 1'b0; rvalid = 1'b0; rlast = 1'b0; sliceend = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int max);
        int n = 0;
        while (!valid && n < max) begin
            tick();
            n++;
        end
        chk(tag, 32'(valid), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_ve", 32'(ve), 32'd0);
        chk("rst_flags", 32'({vl, valid, align, ovf, busy}), 32'd0);
        rst = 1'b0;

        // Single MB: contiguous output from cycle 2
        hset(20'h25, 5'd8, 1'b0); rset(25'h3, 5'd2, 1'b0);
        tick();
        hset(20'h5C2, 5'd12, 1'b0); rset(25'h1, 5'd1, 1'b1);
        tick();
        chk_word("t1_h0", 25'h25, 5'd8);
        clr(); hset(20'h1, 5'd1, 1'b1);
        tick();
        chk_word("t1_h1", 25'h5C2, 5'd12);
        clr();
        tick(); chk_word("t1_h2", 25'h1, 5'd1);
        tick(); chk_word("t1_r0", 25'h3, 5'd2);
        tick(); chk_word("t1_r1", 25'h1, 5'd1);
        tick(); chk_idle("t1_idle");
        chk("t1_ovf_busy", 32'({ovf, busy}), 32'd0);

        // Residual words queued before the header completes
        for (int i = 0; i < 20; i++) begin
            rset(25'(i * 3 + 5), 5'd7, i == 19);
            tick();
        end
        clr();
        chk("t2_busy", 32'(busy), 32'd1);
        hset(20'h7, 5'd3, 1'b0);
        tick();
        hset(20'h2A, 5'd6, 1'b1);
        tick();
        clr();
        wait_valid("t2_wait", 10);
        chk_word("t2_h0", 25'h7, 5'd3);
        tick(); chk_word("t2_h1", 25'h2A, 5'd6);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_word($sformatf("t2_r%0d", i), 25'(i * 3 + 5), 5'd7);
        end
        tick(); chk_idle("t2_idle");

        // Slice end during RES with next-slice header already queued
        hset(20'h9, 5'd4, 1'b1); rset(25'h11, 5'd5, 1'b0);
        tick();
        hset(20'h21, 5'd8, 1'b0); rset(25'h12, 5'd5, 1'b0);
        tick();
        chk_word("t3_h", 25'h9, 5'd4);
        clr(); rset(25'h13, 5'd5, 1'b1); sliceend = 1'b1;
        tick();
        chk_word("t3_r0", 25'h11, 5'd5);
        clr();
        tick(); chk_word("t3_r1", 25'h12, 5'd5);
        tick(); chk_word("t3_r2", 25'h13, 5'd5);
        tick(); chk_idle("t3_gap");
        tick(); chk_word("t3_stop", 25'h1, 5'd1);
        tick(); chk("t3_align", 32'({align, valid}), 32'd2);
        tick(); chk_word("t3_next", 25'h21, 5'd8);
        chk("t3_align_off", 32'(align), 32'd0);
        tick(); chk("t3_busy", 32'({valid, busy}), 32'd0);

        // Zero-length: header marker switches to RES, 0/0 residual discarded
        hset(20'h5, 5'd3, 1'b0); rset(25'h7, 5'd3, 1'b0);
        tick();
        hset(20'h0, 5'd0, 1'b1); rset(25'h0, 5'd0, 1'b0);
        tick();
        chk_word("t4_h0", 25'h5, 5'd3);
        clr(); rset(25'h2, 5'd2, 1'b1);
        tick();
        chk_idle("t4_marker");
        clr();
        tick(); chk_word("t4_r0", 25'h7, 5'd3);
        tick(); chk_word("t4_r1", 25'h2, 5'd2);
        tick(); chk("t4_idle", 32'({valid, busy}), 32'd0);

        // Overflow: 33 residual pushes into a 32-deep FIFO
        for (int i = 0; i < 33; i++) begin
            rset(25'(i + 200), 5'd6, i == 31);
            tick();
            if (i == 31) chk("t5_ovf_32", 32'(ovf), 32'd0);
            if (i == 32) chk("t5_ovf_33", 32'(ovf), 32'd1);
        end
        clr();
        hset(20'h0, 5'd0, 1'b1);
        tick();
        clr();
        wait_valid("t5_wait", 10);
        for (int i = 0; i < 32; i++) begin
            if (i > 0) tick();
            chk_word($sformatf("t5_r%0d", i), 25'(i + 200), 5'd6);
        end
        tick(); chk_idle("t5_idle");
        chk("t5_ovf_sticky", 32'(ovf), 32'd1);

        // Reset mid-MB with residual words queued and a slice end pending
        for (int i = 0; i < 5; i++) begin
            rset(25'(i + 'h40), 5'd4, 1'b0);
            sliceend = (i == 4);
            tick();
        end
        clr();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_valid", 32'(valid), 32'd0);
        chk("t6_align", 32'(align), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_ovf", 32'(ovf), 32'd0);
        tick(); chk("t6_quiet", 32'({valid, align, busy}), 32'd0);
        hset(20'h4, 5'd3, 1'b1); rset(25'h6, 5'd3, 1'b1);
        tick();
        clr();
        tick(); chk_word("t6_h", 25'h4, 5'd3);
        tick(); chk_word("t6_r", 25'h6, 5'd3);
        tick(); chk("t6_end", 32'({valid, busy}), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
